bpred_pc_ctrl: RTL
==================

# bpred_pc_ctrl

Next-PC controller with dynamic branch prediction for the 5-stage pipeline. Each cycle it looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and drives the next-PC value and select into the PC register. It takes branch resolution from EX, trains the table, and on a misprediction issues a redirect PC and a flush to IF/ID.

## Interface
- `DEPTH`, 64: number of BTB entries; must be a power of two, ≥4.
- `IDX_W`, log2(DEPTH): index width; derived, not overridden.
- `clk`  in  1  clock
- `RST`  in  1  synchronous reset, active-high
- `pc_f`  in  32  current fetch PC (PC register output)
- `stall`  in  1  pipeline stall / bubble; freezes training and statistics
- `ex_valid`  in  1  EX stage holds a valid instruction
- `ex_is_branch`  in  1  EX instruction is a conditional branch or jump
- `ex_pc`  in  32  PC of EX instruction
- `ex_taken`  in  1  resolved direction
- `ex_target`  in  32  resolved target
- `ex_pred_taken`  in  1  prediction made for this instruction at fetch (piped along)
- `ex_pred_target`  in  32  predicted target, piped along
- `pred_taken`  out  1  prediction for `pc_f`
- `pred_target`  out  32  BTB target for `pc_f`
- `pc_next`  out  32  value the PC register loads at the next enabled edge
- `flush`  out  1  kill IF and ID contents (misprediction)
- `mispredict_cnt`  out  32  only with `BPRED_STATS_EN`
- `branch_cnt`  out  32  only with `BPRED_STATS_EN`

## Operation
- Entry fields: `valid`, `tag` = `pc[31:IDX_W+2]`, `target[31:0]`, `ctr[1:0]`. Index = `pc[IDX_W+1:2]`.
- Lookup is combinational. `hit` = `valid & tag match`. `pred_taken` = `hit & ctr[1]`. `pred_target` = `hit ? target : pc_f+4`.
- Mispredict = `ex_valid & ex_is_branch & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target))`.
- `pc_next` priority:
  1. mispredict: `ex_taken ? ex_target : ex_pc+4`
  2. otherwise `pred_taken ? pred_target : pc_f+4`
- `flush` = mispredict, combinational.
- Training at the posedge when `ex_valid & ex_is_branch & ~stall & ~RST`:
  - Entry hit on `ex_pc`: counter increments if taken and decrements if not, saturating at 0 and 3. Target is overwritten with `ex_target` when taken.
  - Entry miss and taken: allocate and overwrite with `valid=1`, tag, `ex_target`, `ctr=2`.
  - Entry miss and not taken: no write.
- Adders are 32-bit and wrap modulo 2^32. `0xFFFFFFFC + 4 = 0`.
- Non-branch EX instructions never write the table and never flush.

## Timing
- Lookup and redirect have zero-cycle latency: outputs settle in the same cycle as their inputs.
- Mispredict penalty: 2 cycles, because IF and ID are flushed.
- A training write becomes visible to lookups from the cycle after the edge. If a lookup and an update hit the same index in the same cycle, the lookup sees the old contents; there is no bypass.
- During `stall`, outputs remain combinational, but no table or counter write occurs.
- Reset values:
  - All `valid` = 0, all `ctr` = 1 (weakly not-taken), targets 0.
  - Statistics counters 0.
  - Outputs after reset with `pc_f=0`: `pred_taken=0`, `pred_target=4`, `pc_next=4`, `flush=0`.
- `RST` asserted mid-operation clears the table at that edge. Any update presented in the same cycle is discarded.

## Configuration
- `BPRED_STATS_EN` defined: two 32-bit wrapping counters are built.
  - `branch_cnt` increments on every trained branch.
  - `mispredict_cnt` increments on every mispredict with `~stall`.
- `BPRED_STATS_EN` undefined: both ports and both counters are absent.
- Prediction behaviour is identical either way.

## Structure
- `bpred_pkg` holds:
  - Counter constants `CTR_SNT=0`, `CTR_WNT=1`, `CTR_WT=2`, `CTR_ST=3`.
  - The entry struct type.
  - The `PC_STEP=4` constant.
- Sub-module `bpred_btb` provides register-array storage: one combinational read port and one synchronous write port, with reset clear.
- Next-PC mux, mispredict detection, counter update and statistics live in the top module.

## Test plan
- Reset, then `pc_f=0x100` with no branches → `pred_taken=0`, `pc_next=0x104`, `flush=0`.
- Branch at `0x40` resolves taken to `0x80`, with `ex_pred_taken=0` → `flush=1`, `pc_next=0x80`. At the next cycle, `pc_f=0x40` gives `pred_taken=1`, `pred_target=0x80`.
- Same branch resolves not-taken 2× after allocation (ctr 2→1→0) → 3rd lookup predicts not-taken. Further not-taken results keep ctr at 0.
- Predicted taken to `0x80`, but resolved taken to `0x90` → `flush=1`, `pc_next=0x90`, entry target becomes `0x90`.
- `stall=1` with a resolving branch → no table change, counters unchanged. `pc_next` still reflects the mispredict redirect.
- Aliasing: `0x40` and `0x40+4*DEPTH` both taken → the second replaces the entry, and a lookup of `0x40` then misses. Also wrap: `pc_f=0xFFFFFFFC` on a miss → `pc_next=0`.

Source files
------------

// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared types and constants for the next-PC branch predictor
package bpred_pkg;

    localparam logic [1:0]  CTR_SNT = 2'd0;
    localparam logic [1:0]  CTR_WNT = 2'd1;
    localparam logic [1:0]  CTR_WT  = 2'd2;
    localparam logic [1:0]  CTR_ST  = 2'd3;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Tag field sized for the smallest legal table (4 entries); larger tables leave upper bits zero.
    localparam int TAG_W = 28;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != CTR_ST) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bpred_btb.sv
// rtl/bpred_btb.sv - direct-mapped BTB register array: combinational reads, synchronous write, reset clear
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [IDX_W-1:0] lk_idx,
    output btb_entry_t       lk_entry,
    input  logic [IDX_W-1:0] up_idx,
    output btb_entry_t       up_entry,
    input  logic             wr_en,
    input  btb_entry_t       wr_entry
);

    btb_entry_t mem [DEPTH];

    // Fetch lookup and EX training read independently; writes use the training index.
    assign lk_entry = mem[lk_idx];
    assign up_entry = mem[up_idx];

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= BTB_RESET_ENTRY;
            end
        end else if (wr_en) begin
            mem[up_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/bpred_pc_ctrl.sv
// rtl/bpred_pc_ctrl.sv - next-PC controller with BTB prediction and EX redirect; optional BPRED_STATS_EN counters
module bpred_pc_ctrl
    import bpred_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] pc_f,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] pc_next,
    output logic        flush
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] mispredict_cnt,
    output logic [31:0] branch_cnt
`endif
);

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] ex_tag;
    btb_entry_t       lk_entry;
    btb_entry_t       up_entry;
    btb_entry_t       wr_entry;
    logic             wr_en;
    logic             f_hit;
    logic             ex_hit;
    logic             mispredict;
    logic             train;
    logic [31:0]      pc_f_seq;
    logic [31:0]      ex_pc_seq;

    assign f_idx  = pc_f[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign f_tag  = TAG_W'(pc_f >> (IDX_W + 2));
    assign ex_tag = TAG_W'(ex_pc >> (IDX_W + 2));

    bpred_btb #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_btb (
        .clk      (clk),
        .RST      (RST),
        .lk_idx   (f_idx),
        .lk_entry (lk_entry),
        .up_idx   (ex_idx),
        .up_entry (up_entry),
        .wr_en    (wr_en),
        .wr_entry (wr_entry)
    );

    assign pc_f_seq  = pc_f + PC_STEP;
    assign ex_pc_seq = ex_pc + PC_STEP;

    assign f_hit       = lk_entry.valid && (lk_entry.tag == f_tag);
    assign pred_taken  = f_hit && lk_entry.ctr[1];
    assign pred_target = f_hit ? lk_entry.target : pc_f_seq;

    // A taken branch with the right direction but a stale target is still a redirect.
    assign mispredict = ex_valid && ex_is_branch &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
    assign flush      = mispredict;

    always_comb begin
        pc_next = pc_f_seq;
        if (mispredict) begin
            pc_next = ex_taken ? ex_target : ex_pc_seq;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    assign train  = ex_valid && ex_is_branch && !stall;
    assign ex_hit = up_entry.valid && (up_entry.tag == ex_tag);

    // Not-taken misses are never allocated so cold branches keep falling through.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (train) begin
            if (ex_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_next(up_entry.ctr, ex_taken);
                if (ex_taken) begin
                    wr_entry.target = ex_target;
                end
            end else if (ex_taken) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: CTR_WT};
            end
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge clk) begin
        if (RST) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (!stall) begin
            if (train) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
